// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the fetch, data and main-memory signals of mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_data_out;

    logic              dmem_re;
    logic              dmem_wr;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_data_out;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              oen_mem_re;
    logic              oen_mem_wr;
    logic              mem_ready;
    logic [DATA_W-1:0] data_out;

    // Requesters and main memory
    modport master (
        output imem_req, imem_addr, dmem_re, dmem_wr, dmem_addr, dmem_wdata,
               mem_ready, data_out,
        input  imem_ready, imem_data_out, dmem_ready, dmem_data_out,
               mem_addr, mem_wdata, oen_mem_re, oen_mem_wr
    );

    // The arbiter
    modport slave (
        input  imem_req, imem_addr, dmem_re, dmem_wr, dmem_addr, dmem_wdata,
               mem_ready, data_out,
        output imem_ready, imem_data_out, dmem_ready, dmem_data_out,
               mem_addr, mem_wdata, oen_mem_re, oen_mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (fetch/data) arbiter onto one memory port.
//               MEM_ARB_FAIR_EN adds last-owner starvation avoidance.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              w_dmem_pend;
    logic              w_pick_imem;

    assign w_dmem_pend = bus.dmem_re | bus.dmem_wr;

`ifdef MEM_ARB_FAIR_EN
    logic last_dmem_q;
    logic last_dmem_d;

    // Fetch wins a tie only if data owned the previous grant
    assign w_pick_imem = bus.imem_req & (~w_dmem_pend | last_dmem_q);
    assign last_dmem_d = (state_q != IDLE)  ? last_dmem_q :
                         w_pick_imem        ? 1'b0        :
                         w_dmem_pend        ? 1'b1        : last_dmem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dmem_q <= 1'b0;
        end else begin
            last_dmem_q <= last_dmem_d;
        end
    end
`else
    assign w_pick_imem = bus.imem_req & ~w_dmem_pend;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        wr_d              = wr_q;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.oen_mem_re    = 1'b0;
        bus.oen_mem_wr    = 1'b0;
        bus.imem_ready    = 1'b0;
        bus.imem_data_out = '0;
        bus.dmem_ready    = 1'b0;
        bus.dmem_data_out = '0;

        case (state_q)
            IDLE: begin
                if (w_pick_imem) begin
                    state_d = IGRANT;
                    addr_d  = bus.imem_addr;
                    wdata_d = '0;
                    wr_d    = 1'b0;
                end else if (w_dmem_pend) begin
                    // Simultaneous read and write resolves to the write
                    state_d = DGRANT;
                    addr_d  = bus.dmem_addr;
                    wr_d    = bus.dmem_wr;
                    wdata_d = bus.dmem_wr ? bus.dmem_wdata : '0;
                end
            end
            IGRANT, DGRANT: begin
                bus.mem_addr   = addr_q;
                bus.mem_wdata  = wdata_q;
                bus.oen_mem_wr = wr_q;
                bus.oen_mem_re = ~wr_q;
                if (bus.mem_ready) begin
                    state_d = IDLE;
                    if (state_q == IGRANT) begin
                        bus.imem_ready    = 1'b1;
                        bus.imem_data_out = bus.data_out;
                    end else begin
                        bus.dmem_ready    = 1'b1;
                        bus.dmem_data_out = wr_q ? '0 : bus.data_out;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter, directed plus random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   model_last_dmem = 1'b0;

    mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {re, wr, mem_addr, mem_wdata, imem_ready, imem_data, dmem_ready, dmem_data}
    logic [131:0] obs;
    assign obs = {bus.oen_mem_re, bus.oen_mem_wr, bus.mem_addr, bus.mem_wdata,
                  bus.imem_ready, bus.imem_data_out, bus.dmem_ready, bus.dmem_data_out};

    task automatic clear_inputs();
        bus.imem_req   = 1'b0;
        bus.imem_addr  = '0;
        bus.dmem_re    = 1'b0;
        bus.dmem_wr    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.mem_ready  = 1'b0;
        bus.data_out   = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last_dmem = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.imem_req  = 1'b1;
        bus.dmem_re   = 1'b1;
        bus.dmem_addr = 32'h44;
        bus.mem_ready = 1'b1;
        bus.data_out  = '1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        bus.mem_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.oen_mem_re, bus.oen_mem_wr} !== 2'b00) begin
            n_errors++; $display("FAIL reset_release_no_grant: got %b expected 00",
                                 {bus.oen_mem_re, bus.oen_mem_wr});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.oen_mem_re, bus.oen_mem_wr, bus.mem_addr} !== {2'b10, 32'h44}) begin
            n_errors++; $display("FAIL first_grant_after_reset: got %h expected %h",
                                 {bus.oen_mem_re, bus.oen_mem_wr, bus.mem_addr}, {2'b10, 32'h44});
        end
        apply_reset();
    endtask

    task automatic test_single_fetch();
        logic [131:0] exp;
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h100;
        bus.data_out  = 32'h13;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) bus.imem_addr = 32'h200;
            bus.mem_ready = (c == 2);
            #1;
            exp = {1'b1, 1'b0, 32'h100, 32'h0, (c == 2), (c == 2) ? 32'h13 : 32'h0, 1'b0, 32'h0};
            n_checks++;
            if (obs !== exp) begin
                n_errors++; $display("FAIL fetch_cycle%0d: got %h expected %h", c, obs, exp);
            end
            @(posedge clk);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++; $display("FAIL fetch_return_idle: got %h expected 0", obs);
        end
    endtask

    task automatic test_write();
        logic [131:0] exp;
        bus.dmem_wr    = 1'b1;
        bus.dmem_addr  = 32'h2000;
        bus.dmem_wdata = 32'hDEADBEEF;
        bus.data_out   = 32'h12345678;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.mem_ready = (c == 1);
            #1;
            exp = {1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 1'b0, 32'h0, (c == 1), 32'h0};
            n_checks++;
            if (obs !== exp) begin
                n_errors++; $display("FAIL write_cycle%0d: got %h expected %h", c, obs, exp);
            end
            @(posedge clk);
        end
        @(negedge clk);
        clear_inputs();
        bus.mem_ready = 1'b1;
        bus.data_out  = 32'hCAFEF00D;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++; $display("FAIL stray_mem_ready_idle: got %h expected 0", obs);
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_contention();
        bit exp_d;
        apply_reset();
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h100;
        bus.dmem_re   = 1'b1;
        bus.dmem_addr = 32'h300;
        bus.data_out  = 32'h55;
        for (int t = 0; t < 4; t++) begin
            exp_d = FAIR ? (t % 2 == 0) : 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.mem_ready = 1'b1;
            #1;
            n_checks++;
            if ({bus.mem_addr, bus.imem_ready, bus.dmem_ready} !==
                {exp_d ? 32'h300 : 32'h100, !exp_d, exp_d}) begin
                n_errors++; $display("FAIL contention_txn%0d: got addr %h ir %b dr %b expected dmem_owner %b",
                                     t, bus.mem_addr, bus.imem_ready, bus.dmem_ready, exp_d);
            end
            @(posedge clk);
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            n_checks++;
            if ({bus.oen_mem_re, bus.oen_mem_wr} !== 2'b00) begin
                n_errors++; $display("FAIL contention_gap%0d: got %b expected 00",
                                     t, {bus.oen_mem_re, bus.oen_mem_wr});
            end
        end
        model_last_dmem = FAIR ? 1'b0 : 1'b1;
        clear_inputs();
    endtask

    task automatic test_reset_mid_grant();
        @(negedge clk);
        bus.dmem_re   = 1'b1;
        bus.dmem_addr = 32'h40;
        @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if ({bus.oen_mem_re, bus.oen_mem_wr, bus.mem_addr} !== {2'b10, 32'h40}) begin
            n_errors++; $display("FAIL midgrant_strobe: got %h expected %h",
                                 {bus.oen_mem_re, bus.oen_mem_wr, bus.mem_addr}, {2'b10, 32'h40});
        end
        #2 rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.data_out  = 32'h77;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++; $display("FAIL midgrant_async_reset: got %h expected 0", obs);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_last_dmem = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++; $display("FAIL midgrant_no_replay: got %h expected 0", obs);
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [131:0] exp;
        logic [31:0]  iaddr, daddr, wdat, rdata, e_addr, e_wd;
        bit           ireq, dre, dwr, take_i, take_d, e_wr, done;
        int           lat;
        for (int it = 0; it < 80; it++) begin
            @(negedge clk);
            ireq  = ($urandom_range(0, 3) != 0);
            dre   = $urandom_range(0, 1);
            dwr   = ($urandom_range(0, 2) == 0);
            iaddr = $urandom; daddr = $urandom; wdat = $urandom;
            bus.imem_req = ireq; bus.imem_addr = iaddr;
            bus.dmem_re = dre; bus.dmem_wr = dwr;
            bus.dmem_addr = daddr; bus.dmem_wdata = wdat;
            bus.mem_ready = ($urandom_range(0, 3) == 0);
            bus.data_out  = $urandom;
            #1;
            n_checks++;
            if (obs !== '0) begin
                n_errors++; $display("FAIL rand%0d_idle: got %h expected 0", it, obs);
            end
            take_i = ireq && (!(dre || dwr) || (FAIR && model_last_dmem));
            take_d = (dre || dwr) && !take_i;
            e_addr = take_i ? iaddr : daddr;
            e_wr   = take_d && dwr;
            e_wd   = e_wr ? wdat : 32'h0;
            @(posedge clk);
            if (take_i || take_d) begin
                model_last_dmem = take_d;
                lat = $urandom_range(0, 3);
                for (int k = 0; k <= lat; k++) begin
                    @(negedge clk);
                    bus.imem_req   = $urandom_range(0, 1);
                    bus.imem_addr  = $urandom;
                    bus.dmem_re    = $urandom_range(0, 1);
                    bus.dmem_wr    = $urandom_range(0, 1);
                    bus.dmem_addr  = $urandom;
                    bus.dmem_wdata = $urandom;
                    done  = (k == lat);
                    rdata = $urandom;
                    bus.mem_ready = done;
                    bus.data_out  = rdata;
                    #1;
                    exp = {!e_wr, e_wr, e_addr, e_wd,
                           done && take_i, (done && take_i) ? rdata : 32'h0,
                           done && take_d, (done && take_d && !e_wr) ? rdata : 32'h0};
                    n_checks++;
                    if (obs !== exp) begin
                        n_errors++; $display("FAIL rand%0d_grant_cycle%0d: got %h expected %h",
                                             it, k, obs, exp);
                    end
                    @(posedge clk);
                end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_write();
        test_contention();
        test_reset_mid_grant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
